seq_detect_sched: RTL
=====================

# seq_detect_sched

Shared-engine pattern-detect scheduler: accepts serial bit streams from NCH independent channels, buffers one bit per channel, and time-multiplexes a single pattern-match engine among them by round-robin arbitration. Per-channel match history is kept so each stream behaves as if it had a private detector. Sits between the serial front-ends and the event/statistics logic, replacing NCH copies of the bit-serial detector.

## Interface
- NCH, 4, number of input channels (2..8)
- PLEN, 4, pattern length in bits (2..16)
- PATTERN, 4'b1101, target pattern; MSB is the oldest bit
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  asynchronous, active-high reset
- din  in  NCH  serial data bit per channel
- din_vld  in  NCH  din[i] is valid this cycle
- ovf_clr  in  1  clears all ovf bits
- flag  out  NCH  one-cycle match pulse per channel
- gnt_vld  out  1  engine processed a bit this cycle
- gnt_id  out  clog2(NCH)  channel processed when gnt_vld=1
- ovf  out  NCH  sticky per-channel overflow
- match_cnt  out  8  total matches, saturating

## Operation
- Reset: flag, gnt_vld, gnt_id, ovf, match_cnt all 0. Pending bits, histories, fill counts and the round-robin pointer are all 0.
- Capture, per channel i with din_vld[i]=1:
  - If no bit is pending, or the pending bit is granted at this edge: store din[i] and set pend[i].
  - Otherwise: drop din[i], keep the old pending bit, set ovf[i].
- Arbitration:
  - Grant the lowest channel index >= ptr (wrapping modulo NCH) that has pend set.
  - At most one grant per edge.
  - After a grant, ptr = gnt+1 mod NCH. With no grant, ptr holds.
- Engine, for granted channel g:
  - win = {hist[g], pbit[g]}, PLEN bits.
  - Match when win==PATTERN and fill[g]==PLEN-1.
  - Update: hist[g] <= win[PLEN-2:0]; fill[g] increments, saturating at PLEN-1; pend[g] clears unless recaptured.
- Outputs, registered:
  - flag[g]=1 for one cycle on a match.
  - gnt_vld=1 and gnt_id=g for every grant.
  - match_cnt increments on a match and holds at 255.
- ovf_clr clears ovf. An overflow on the same edge wins (bit stays 1).

## Timing
- A bit captured at edge k is processed no earlier than edge k+1; flag is high from edge k+1 to edge k+2.
- Worst-case service interval per channel is NCH cycles. A channel sending one bit every NCH cycles or slower never overflows.
- Reset asserted mid-stream clears all state immediately, including partial histories. The first post-reset match needs PLEN fresh bits.
- A channel's own new bit and its grant on the same edge: old bit consumed, new bit captured, no ovf.

## Configuration
- SEQ_SCHED_OVERLAP_EN defined: overlapping detection; history is kept after a match.
- SEQ_SCHED_OVERLAP_EN undefined: on a match, hist[g] and fill[g] of that channel clear to 0, so the next match needs PLEN new bits.

## Test plan
- ch0 sends 1,1,0,1, one bit every 4 cycles, other channels idle:
  - exactly one flag[0] pulse, one cycle after the 4th bit's capture edge;
  - match_cnt=1; ovf=0.
- ch1 sends 1,1,0,1,1,0,1:
  - with SEQ_SCHED_OVERLAP_EN, two flag[1] pulses, match_cnt=2;
  - without it, one pulse, match_cnt=1.
- All four channels din_vld=1 every cycle for 8 cycles from reset:
  - gnt_id sequence is 0,1,2,3,0,1,2,3;
  - ovf=4'b1110 after the second edge;
  - ovf_clr pulsed while overflows continue leaves those bits at 1.
- ch2 sends 1,1,0, then rst pulses, then ch2 sends 1:
  - no flag; ovf=0; match_cnt=0;
  - then 1,1,0,1 gives one flag[2].
- ch3 streams 1101 repeated 300 times, one bit every 4 cycles:
  - match_cnt saturates at 255 and holds;
  - flag[3] still pulses for every match.

Source files
------------

// File: rtl/seq_detect_sched_if.sv
// Bundle of per-channel serial inputs and engine/status outputs for seq_detect_sched.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives data/valid, the slave reports grants, flags and overflow.
interface seq_detect_sched_if #(
  parameter int NCH = 4
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] din;
  logic [NCH-1:0] din_vld;
  logic           ovf_clr;
  logic [NCH-1:0] flag;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [NCH-1:0] ovf;
  logic [7:0]     match_cnt;

  modport master (
    output din, din_vld, ovf_clr,
    input  flag, gnt_vld, gnt_id, ovf, match_cnt
  );

  modport slave (
    input  din, din_vld, ovf_clr,
    output flag, gnt_vld, gnt_id, ovf, match_cnt
  );
endinterface

// File: rtl/seq_detect_sched.sv
// Round-robin shared pattern-match engine serving NCH serial channels, one bit buffered per channel.
// Latency: bit captured at falling edge k is matched at edge k+1 at the earliest; outputs registered.
// Backpressure: none upstream; a bit arriving while its slot is still occupied is dropped and sets sticky ovf.
// Option: define SEQ_SCHED_OVERLAP_EN to keep match history after a hit (overlapping detection).
module seq_detect_sched #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1101
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_sched_if.slave  bus
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW  = $clog2(PLEN);
  localparam int HW  = PLEN - 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(PLEN - 1);

  // per-channel buffered bit and private detector history
  logic [NCH-1:0] pend;
  logic [NCH-1:0] pbit;
  logic [HW-1:0]  hist [NCH];
  logic [FW-1:0]  fill [NCH];
  logic [IDW-1:0] ptr;

  // registered outputs
  logic [NCH-1:0] flag_q;
  logic           gnt_vld_q;
  logic [IDW-1:0] gnt_id_q;
  logic [NCH-1:0] ovf_q;
  logic [7:0]     cnt_q;

  // combinational arbitration / engine results
  logic           gnt_hit;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] cand;
  logic [NCH-1:0] gnt_oh;
  logic [PLEN-1:0] win;
  logic           hit;
  logic [NCH-1:0] take;
  logic [NCH-1:0] ovf_set;

  assign bus.flag      = flag_q;
  assign bus.gnt_vld   = gnt_vld_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.ovf       = ovf_q;
  assign bus.match_cnt = cnt_q;

  // Round-robin pick: first pending channel at or after ptr, wrapping.
  always_comb begin
    gnt_hit = 1'b0;
    gnt     = '0;
    cand    = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = IDW'((int'(ptr) + k) % NCH);
      if (!gnt_hit && pend[cand]) begin
        gnt_hit      = 1'b1;
        gnt          = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

  // Engine window for the granted channel and capture/drop decision for every channel.
  always_comb begin
    win     = {hist[gnt], pbit[gnt]};
    hit     = gnt_hit && (win == PATTERN) && (fill[gnt] == FILL_FULL);
    // a slot being drained this edge can accept the channel's next bit
    take    = bus.din_vld & (~pend | gnt_oh);
    ovf_set = bus.din_vld & pend & ~gnt_oh;
  end

  // Capture into the one-bit buffers and maintain sticky overflow (a new overflow beats ovf_clr).
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      pbit  <= '0;
      ovf_q <= '0;
    end else begin
      pend  <= take | (pend & ~gnt_oh);
      pbit  <= (pbit & ~take) | (bus.din & take);
      ovf_q <= (ovf_q & ~{NCH{bus.ovf_clr}}) | ovf_set;
    end
  end

  // Advance the granted channel's history and fill count.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else if (gnt_hit) begin
`ifdef SEQ_SCHED_OVERLAP_EN
      hist[gnt] <= win[PLEN-2:0];
      if (fill[gnt] != FILL_FULL) fill[gnt] <= fill[gnt] + 1'b1;
`else
      if (hit) begin
        // non-overlapping: next match needs PLEN fresh bits
        hist[gnt] <= '0;
        fill[gnt] <= '0;
      end else begin
        hist[gnt] <= win[PLEN-2:0];
        if (fill[gnt] != FILL_FULL) fill[gnt] <= fill[gnt] + 1'b1;
      end
`endif
    end
  end

  // Registered grant/flag outputs, saturating match counter and round-robin pointer.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      flag_q    <= '0;
      gnt_vld_q <= 1'b0;
      gnt_id_q  <= '0;
      cnt_q     <= '0;
      ptr       <= '0;
    end else begin
      flag_q    <= hit ? gnt_oh : '0;
      gnt_vld_q <= gnt_hit;
      if (gnt_hit) begin
        gnt_id_q <= gnt;
        ptr      <= (gnt == IDW'(NCH - 1)) ? '0 : gnt + 1'b1;
      end
      if (hit && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end
endmodule
